btc_ctrl_rb: RTL and testbench

//   Parametrised bit-chain configuration segment with a control FSM: counted programming,
//   non-destructive readback by rotation, and done/error status. Successor to the plain

---
 rtl/btc_ctrl_rb.sv | 98 +++++++++
 tb/tb_btc_ctrl_rb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btc_ctrl_rb.sv
// rtl/btc_ctrl_rb.sv - bit-chain config segment with counted program, rotating readback and status FSM
module btc_ctrl_rb #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s,
  input  logic                   m,
  input  logic                   e,
  input  logic [WIDTH-1:0]       i,
  output logic [WIDTH-1:0]       o,
  output logic [WIDTH*DEPTH-1:0] d,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [CNT_W-1:0]       cnt
);

  typedef enum logic [1:0] {IDLE, PROG, READ, DONE} state_t;

  state_t                 state;
  logic [WIDTH*DEPTH-1:0] prog_next;
  logic [WIDTH*DEPTH-1:0] read_next;
  logic                   last;

  // Oldest word sits at the top of the chain and leaves first.
  assign o    = d[WIDTH*DEPTH-1 -: WIDTH];
  assign last = (cnt == CNT_W'(DEPTH - 1));

  // A one-word segment has nothing to shift past: programming replaces the
  // word and readback leaves it in place.
  generate
    if (DEPTH == 1) begin : g_single
      assign prog_next = i;
      assign read_next = d;
    end else begin : g_chain
      assign prog_next = {d[WIDTH*(DEPTH-1)-1:0], i};
      assign read_next = {d[WIDTH*(DEPTH-1)-1:0], o};
    end
  endgenerate

  // Control FSM; busy/done are registered alongside the state they decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      d     <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (s) begin
            // A strobe coincident with start is dropped; first word comes next cycle.
            cnt   <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= m ? READ : PROG;
          end else if (e) begin
            err <= 1'b1;
          end
        end
        PROG: begin
          if (e) begin
            d   <= prog_next;
            cnt <= cnt + 1'b1;
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          if (e) begin
            d   <= read_next;
            cnt <= cnt + 1'b1;
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btc_ctrl_rb.sv
// tb/tb_btc_ctrl_rb.sv - scoreboard bench for btc_ctrl_rb against a word-queue reference model
module tb_btc_ctrl_rb;

  localparam int W  = 4;
  localparam int D  = 3;
  localparam int CW = $clog2(D + 1);

  logic             clk;
  logic             rst_n;
  logic             s, m, e;
  logic [W-1:0]     i;
  logic [W-1:0]     o;
  logic [W*D-1:0]   d;
  logic             busy, done, err;
  logic [CW-1:0]    cnt;

  logic             s1, m1, e1;
  logic [W-1:0]     i1, o1;
  logic [W-1:0]     d1;
  logic             busy1, done1, err1;
  logic             cnt1;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cycles = 0;
  logic rd_mode = 1'b0;
  logic done_q = 1'b0;

  typedef struct {
    logic [W*D-1:0] dv;
    logic [CW-1:0]  cv;
  } fin_t;

  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_o[$];
  fin_t         exp_fin[$];

  btc_ctrl_rb #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .s(s), .m(m), .e(e), .i(i),
    .o(o), .d(d), .busy(busy), .done(done), .err(err), .cnt(cnt)
  );

  btc_ctrl_rb #(.WIDTH(W), .DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .s(s1), .m(m1), .e(e1), .i(i1),
    .o(o1), .d(d1), .busy(busy1), .done(done1), .err(err1), .cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the segment holds the last D words written, oldest first.
  task automatic model_reset();
    model_q.delete();
    for (int k = 0; k < D; k++) model_q.push_back('0);
  endtask

  function automatic logic [W*D-1:0] model_d();
    logic [W*D-1:0] r;
    r = '0;
    for (int k = 0; k < D; k++) r[k*W +: W] = model_q[D-1-k];
    return r;
  endfunction

  // Monitor: compares readback words as the DUT presents them, and final state on done.
  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (busy && e && rd_mode) begin
      if (exp_o.size() == 0) chk("readback_unexpected", 1, 0);
      else chk("readback_o", o, exp_o.pop_front());
    end
    if (done && !done_q) begin
      if (exp_fin.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        fin_t f;
        f = exp_fin.pop_front();
        chk("done_d", d, f.dv);
        chk("done_cnt", cnt, f.cv);
      end
    end
    done_q = done;
  end

  task automatic strobe(input logic ev, input logic [W-1:0] iv);
    e = ev;
    i = iv;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic mode);
    s = 1'b1;
    m = mode;
    rd_mode = mode;
    e = 1'($urandom_range(0, 1));
    i = W'($urandom);
    @(posedge clk);
    #1;
    s = 1'b0;
    e = 1'b0;
    chk("start_err_clear", err, 0);
    chk("start_busy", busy, 1);
    chk("start_cnt", cnt, 0);
    chk("start_done_clear", done, 0);
  endtask

  // words[k*W +: W] is the k-th word sent.
  task automatic do_prog(input logic [W*D-1:0] words, input int maxgap);
    fin_t f;
    for (int k = 0; k < D; k++) begin
      model_q.push_back(words[k*W +: W]);
      void'(model_q.pop_front());
    end
    f.dv = model_d();
    f.cv = CW'(D);
    exp_fin.push_back(f);
    start(1'b0);
    for (int k = 0; k < D; k++) begin
      repeat ($urandom_range(0, maxgap)) strobe(1'b0, W'($urandom));
      strobe(1'b1, words[k*W +: W]);
    end
    e = 1'b0;
  endtask

  task automatic do_read(input int maxgap);
    fin_t f;
    foreach (model_q[k]) exp_o.push_back(model_q[k]);
    f.dv = model_d();
    f.cv = CW'(D);
    exp_fin.push_back(f);
    start(1'b1);
    for (int k = 0; k < D; k++) begin
      repeat ($urandom_range(0, maxgap)) strobe(1'b0, W'($urandom));
      strobe(1'b1, W'($urandom));
    end
    e = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_d"}, d, 0);
    chk({tag, "_o"}, o, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_cnt"}, cnt, 0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_o.delete();
    exp_fin.delete();
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    s = 0; m = 0; e = 0; i = '0;
    s1 = 0; m1 = 0; e1 = 0; i1 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("init");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed program 1,2,3 without gaps.
    busy_cycles = 0;
    do_prog(12'h321, 0);
    chk("prog_d", d, 12'h123);
    chk("prog_o", o, 4'h1);
    chk("prog_done", done, 1);
    chk("prog_cnt", cnt, 3);
    chk("prog_busy_cycles", busy_cycles, 3);

    // Readback: oldest first, segment restored.
    do_read(0);
    chk("read_d", d, 12'h123);
    chk("read_done", done, 1);

    // Gapped strobes with a stray start mid-program.
    begin
      fin_t f;
      model_reset();
      for (int k = 1; k <= 3; k++) begin
        model_q.push_back(W'(k));
        void'(model_q.pop_front());
      end
      f.dv = model_d();
      f.cv = CW'(D);
      exp_fin.push_back(f);
      start(1'b0);
      strobe(1'b1, 4'h1);
      s = 1'b1; m = 1'b1;
      strobe(1'b0, 4'h9);
      chk("gap_cnt1", cnt, 1);
      s = 1'b0;
      strobe(1'b0, 4'h7);
      chk("gap_cnt2", cnt, 1);
      chk("gap_busy", busy, 1);
      strobe(1'b1, 4'h2);
      strobe(1'b1, 4'h3);
      e = 1'b0;
      chk("gap_d", d, 12'h123);
      chk("gap_done", done, 1);
      chk("gap_cnt_end", cnt, 3);
    end

    // Stray strobe in DONE flags err and leaves the segment alone.
    strobe(1'b1, 4'hF);
    e = 1'b0;
    chk("err_set", err, 1);
    chk("err_d", d, model_d());
    chk("err_cnt", cnt, 3);
    chk("err_done_held", done, 1);
    strobe(1'b0, 4'h0);
    chk("err_sticky", err, 1);
    do_read(1);
    chk("read2_d", d, 12'h123);

    // Async reset mid-cycle after loading.
    async_reset();
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    strobe(1'b1, 4'h5);
    e = 1'b0;
    chk("idle_err", err, 1);
    chk("idle_d", d, 0);

    // Reset mid-readback after one strobe.
    do_prog(W*D'($urandom), 1);
    foreach (model_q[k]) exp_o.push_back(model_q[k]);
    start(1'b1);
    strobe(1'b1, 4'h0);
    e = 1'b0;
    chk("midread_cnt", cnt, 1);
    async_reset();
    check_reset_outputs("midread_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomised mix of programming, readback and stray strobes.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: do_prog(W*D'($urandom), 2);
        1: do_read(2);
        default: begin
          strobe(1'b1, W'($urandom));
          e = 1'b0;
          chk("rand_err", err, 1);
          chk("rand_err_d", d, model_d());
        end
      endcase
    end

    // DEPTH=1 segment.
    s1 = 1'b1; m1 = 1'b0;
    @(posedge clk); #1;
    s1 = 1'b0;
    chk("d1_busy", busy1, 1);
    e1 = 1'b1; i1 = 4'hA;
    @(posedge clk); #1;
    e1 = 1'b0;
    chk("d1_prog_d", d1, 4'hA);
    chk("d1_prog_done", done1, 1);
    chk("d1_prog_cnt", cnt1, 1);
    s1 = 1'b1; m1 = 1'b1;
    @(posedge clk); #1;
    s1 = 1'b0;
    e1 = 1'b1; i1 = 4'h3;
    #2;
    chk("d1_read_o", o1, 4'hA);
    @(posedge clk); #1;
    e1 = 1'b0;
    chk("d1_read_d", d1, 4'hA);
    chk("d1_read_done", done1, 1);
    chk("d1_read_err", err1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("exp_o_drained", exp_o.size(), 0);
    chk("exp_fin_drained", exp_fin.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
